// File: rtl/tx_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tx_unpacker
// Description : Pops one interleaved frame from a show-ahead TX FIFO per
//               txstrobe and fans it out to up to 8 registered 16-bit channel
//               outputs, in 16-bit or 8-bit (two samples per word) format.
//               Optional macro TX_UNDERRUN_HOLD_EN: an underrun keeps the last
//               good frame on the outputs instead of transmitting silence.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_unpacker #(
  parameter int LEVEL_W = 12
) (
  input  logic               rxclk,
  input  logic               reset,
  input  logic [3:0]         channels,
  input  logic               fmt_8bit,
  input  logic [15:0]        fifo_q,
  input  logic               fifo_empty,
  input  logic [LEVEL_W-1:0] fifo_level,
  output logic               fifo_rdreq,
  input  logic               txstrobe,
  input  logic               clear_status,
  output logic               tx_underrun,
  output logic               frame_valid,
  output logic [15:0]        ch_0,
  output logic [15:0]        ch_1,
  output logic [15:0]        ch_2,
  output logic [15:0]        ch_3,
  output logic [15:0]        ch_4,
  output logic [15:0]        ch_5,
  output logic [15:0]        ch_6,
  output logic [15:0]        ch_7,
  output logic [15:0]        debugbus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  state_t      state_q;
  logic [3:0]  idx_q;
  logic        underrun_q;
  logic        frame_valid_q;
  logic [15:0] stage_q [8];
  logic [15:0] stage_d [8];
  logic [15:0] ch_q    [8];
  logic [15:0] ch_d    [8];

  logic [3:0]  ch_n;
  logic [3:0]  words_needed;
  logic        level_ok;
  logic        pop;
  logic        last_pop;
  logic        underrun_set;

  assign ch_n         = (channels > 4'd8) ? 4'd8 : channels;
  assign words_needed = fmt_8bit ? ({1'b0, ch_n[3:1]} + {3'b000, ch_n[0]}) : ch_n;
  assign level_ok     = (fifo_level >= LEVEL_W'(words_needed));

  // Reset gates the pop so an aborted load never consumes another word.
  assign pop          = (state_q == ST_LOAD) && !fifo_empty && !reset;
  assign fifo_rdreq   = pop;
  assign last_pop     = pop && ((idx_q + 4'd1) == words_needed);

  assign underrun_set = txstrobe &&
                        ((state_q == ST_LOAD) || ((ch_n != 4'd0) && !level_ok));

  // Staging view including the word being popped this cycle, so the final
  // pop and the channel update happen on the same edge.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      stage_d[i] = stage_q[i];
    end
    stage_d[idx_q[2:0]] = fifo_q;
  end

  for (genvar g = 0; g < 8; g++) begin : g_unpack
    assign ch_d[g] = (4'(g) >= ch_n) ? 16'h0000 :
                     fmt_8bit        ? {stage_d[g/2][8*(g%2) +: 8], 8'h00} :
                                       stage_d[g];
  end

  always_ff @(posedge rxclk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= 4'd0;
      underrun_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        stage_q[i] <= 16'h0000;
        ch_q[i]    <= 16'h0000;
      end
    end else begin
      frame_valid_q <= 1'b0;

      if (underrun_set) begin
        underrun_q <= 1'b1;
      end else if (clear_status) begin
        underrun_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (txstrobe && (ch_n != 4'd0)) begin
            if (level_ok) begin
              state_q <= ST_LOAD;
              idx_q   <= 4'd0;
            end else begin
`ifdef TX_UNDERRUN_HOLD_EN
              // last good frame stays on the outputs
`else
              for (int i = 0; i < 8; i++) begin
                ch_q[i] <= 16'h0000;
              end
              frame_valid_q <= 1'b1;
`endif
            end
          end
        end
        ST_LOAD: begin
          if (pop) begin
            for (int i = 0; i < 8; i++) begin
              stage_q[i] <= stage_d[i];
            end
            idx_q <= idx_q + 4'd1;
            if (last_pop) begin
              for (int i = 0; i < 8; i++) begin
                ch_q[i] <= ch_d[i];
              end
              frame_valid_q <= 1'b1;
              state_q       <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_underrun = underrun_q;
  assign frame_valid = frame_valid_q;
  assign ch_0        = ch_q[0];
  assign ch_1        = ch_q[1];
  assign ch_2        = ch_q[2];
  assign ch_3        = ch_q[3];
  assign ch_4        = ch_q[4];
  assign ch_5        = ch_q[5];
  assign ch_6        = ch_q[6];
  assign ch_7        = ch_q[7];

  assign debugbus = {2'b00, ch_n, idx_q, frame_valid_q, (state_q == ST_LOAD),
                     txstrobe, fifo_empty, underrun_q, fifo_rdreq};

endmodule
`default_nettype wire

// File: tb/tb_tx_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_unpacker
// Description : Self-checking bench for tx_unpacker: vector table of frames
//               plus directed sequences for timing, underrun and reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_unpacker;

  logic        rxclk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  channels = 4'd0;
  logic        fmt_8bit = 1'b0;
  logic [15:0] fifo_q;
  logic        fifo_empty;
  logic [11:0] fifo_level;
  logic        fifo_rdreq;
  logic        txstrobe = 1'b0;
  logic        clear_status = 1'b0;
  logic        tx_underrun;
  logic        frame_valid;
  logic [15:0] ch [8];
  logic [15:0] debugbus;

  // Show-ahead FIFO model: pointers only move forward, flush = wr_ptr := rd_ptr.
  logic [15:0] mem [64];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int pop_cnt = 0;
  int rdreq_cnt = 0;
  int tests = 0;
  int failed = 0;

  assign fifo_q     = mem[rd_ptr[5:0]];
  assign fifo_level = 12'(wr_ptr - rd_ptr);
  assign fifo_empty = (wr_ptr == rd_ptr);

  always #5 rxclk = ~rxclk;

  always @(posedge rxclk) begin
    if (fifo_rdreq) rdreq_cnt <= rdreq_cnt + 1;
    if (fifo_rdreq && !fifo_empty) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  tx_unpacker #(.LEVEL_W(12)) dut (
    .rxclk(rxclk), .reset(reset), .channels(channels), .fmt_8bit(fmt_8bit),
    .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
    .fifo_rdreq(fifo_rdreq), .txstrobe(txstrobe), .clear_status(clear_status),
    .tx_underrun(tx_underrun), .frame_valid(frame_valid),
    .ch_0(ch[0]), .ch_1(ch[1]), .ch_2(ch[2]), .ch_3(ch[3]),
    .ch_4(ch[4]), .ch_5(ch[5]), .ch_6(ch[6]), .ch_7(ch[7]),
    .debugbus(debugbus)
  );

  typedef struct packed {
    logic [3:0]        chans;
    logic              fmt;
    logic [3:0]        nw;
    logic [7:0][15:0]  w;
    logic [7:0][15:0]  exp;
    logic [3:0]        pops;
    logic              und;
    logic [3:0]        lat;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [3:0] c, input logic f, input logic [3:0] nw,
                              input logic [127:0] w, input logic [127:0] e,
                              input logic [3:0] p, input logic u, input logic [3:0] l);
    vec_t v;
    v.chans = c; v.fmt = f; v.nw = nw; v.w = w; v.exp = e;
    v.pops = p; v.und = u; v.lat = l;
    return v;
  endfunction

  task automatic tick();
    @(posedge rxclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr++;
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
  endtask

  task automatic clear_flag();
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
  endtask

  initial begin
    int p0, lat, nfv, r0;

    vecs[0] = mk(4'd2, 1'b0, 4'd2, {96'h0, 16'h2222, 16'h1111},
                 {96'h0, 16'h2222, 16'h1111}, 4'd2, 1'b0, 4'd3);
    vecs[1] = mk(4'd4, 1'b1, 4'd2, {96'h0, 16'hC3D4, 16'hA1B2},
                 {64'h0, 16'hC300, 16'hD400, 16'hA100, 16'hB200}, 4'd2, 1'b0, 4'd3);
    vecs[2] = mk(4'd3, 1'b1, 4'd2, {96'h0, 16'h5678, 16'h1234},
                 {80'h0, 16'h7800, 16'h1200, 16'h3400}, 4'd2, 1'b0, 4'd3);
`ifdef TX_UNDERRUN_HOLD_EN
    vecs[3] = mk(4'd4, 1'b0, 4'd3, {80'h0, 16'h0003, 16'h0002, 16'h0001},
                 {80'h0, 16'h7800, 16'h1200, 16'h3400}, 4'd0, 1'b1, 4'd0);
`else
    vecs[3] = mk(4'd4, 1'b0, 4'd3, {80'h0, 16'h0003, 16'h0002, 16'h0001},
                 128'h0, 4'd0, 1'b1, 4'd1);
`endif
    vecs[4] = mk(4'd12, 1'b0, 4'd8,
                 {16'h8008, 16'h7007, 16'h6006, 16'h5005, 16'h4004, 16'h3003, 16'h2002, 16'h1001},
                 {16'h8008, 16'h7007, 16'h6006, 16'h5005, 16'h4004, 16'h3003, 16'h2002, 16'h1001},
                 4'd8, 1'b0, 4'd9);
    vecs[5] = mk(4'd1, 1'b1, 4'd1, {112'h0, 16'hABCD}, {112'h0, 16'hCD00},
                 4'd1, 1'b0, 4'd2);
    vecs[6] = mk(4'd8, 1'b1, 4'd4, {64'h0, 16'h0708, 16'h0506, 16'h0304, 16'h0102},
                 {16'h0700, 16'h0800, 16'h0500, 16'h0600, 16'h0300, 16'h0400, 16'h0100, 16'h0200},
                 4'd4, 1'b0, 4'd5);
    vecs[7] = mk(4'd15, 1'b1, 4'd5,
                 {48'h0, 16'hEEEE, 16'h8899, 16'h6677, 16'h4455, 16'h2233},
                 {16'h8800, 16'h9900, 16'h6600, 16'h7700, 16'h4400, 16'h5500, 16'h2200, 16'h3300},
                 4'd4, 1'b0, 4'd5);

    // Reset state
    repeat (3) tick();
    check("rst rdreq", 32'(fifo_rdreq), 0);
    check("rst underrun", 32'(tx_underrun), 0);
    check("rst frame_valid", 32'(frame_valid), 0);
    for (int k = 0; k < 8; k++) check($sformatf("rst ch%0d", k), 32'(ch[k]), 0);
    check("rst debugbus", 32'(debugbus), 32'h0004);
    reset = 1'b0;
    tick();

    // Exact latency: 2 words, pops at T+1,T+2, outputs at T+3
    channels = 4'd2; fmt_8bit = 1'b0;
    push(16'h1111); push(16'h2222);
    txstrobe = 1'b1; tick(); txstrobe = 1'b0;
    check("lat T+1 rdreq", 32'(fifo_rdreq), 1);
    check("lat T+1 state", 32'(debugbus[4]), 1);
    tick();
    check("lat T+2 rdreq", 32'(fifo_rdreq), 1);
    check("lat T+2 fv", 32'(frame_valid), 0);
    tick();
    check("lat T+3 rdreq", 32'(fifo_rdreq), 0);
    check("lat T+3 fv", 32'(frame_valid), 1);
    check("lat T+3 ch0", 32'(ch[0]), 32'h1111);
    check("lat T+3 ch1", 32'(ch[1]), 32'h2222);
    check("lat T+3 underrun", 32'(tx_underrun), 0);
    tick();

    // Vector table
    for (int i = 0; i < NVEC; i++) begin
      channels = vecs[i].chans; fmt_8bit = vecs[i].fmt;
      flush();
      for (int k = 0; k < int'(vecs[i].nw); k++) push(vecs[i].w[k]);
      clear_flag();
      p0 = pop_cnt;
      txstrobe = 1'b1; tick(); txstrobe = 1'b0;
      lat = 0; nfv = 0;
      for (int c = 1; c <= 12; c++) begin
        if (frame_valid) begin
          nfv++;
          if (lat == 0) lat = c;
        end
        tick();
      end
      check($sformatf("v%0d pops", i), 32'(pop_cnt - p0), 32'(vecs[i].pops));
      check($sformatf("v%0d underrun", i), 32'(tx_underrun), 32'(vecs[i].und));
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d fv count", i), 32'(nfv), (vecs[i].lat != 0) ? 32'd1 : 32'd0);
      for (int k = 0; k < 8; k++)
        check($sformatf("v%0d ch%0d", i, k), 32'(ch[k]), 32'(vecs[i].exp[k]));
    end

    // Underrun flag: clear, then set+clear in the same cycle
    channels = 4'd4; fmt_8bit = 1'b0;
    flush(); clear_flag();
    push(16'h0001); push(16'h0002); push(16'h0003);
    txstrobe = 1'b1; tick(); txstrobe = 1'b0;
    check("ur set", 32'(tx_underrun), 1);
    check("ur no rdreq", 32'(fifo_rdreq), 0);
    clear_flag();
    check("ur cleared", 32'(tx_underrun), 0);
    clear_status = 1'b1; txstrobe = 1'b1; tick();
    clear_status = 1'b0; txstrobe = 1'b0;
    check("ur set beats clear", 32'(tx_underrun), 1);

    // Strobe during LOAD: flagged, load completes
    channels = 4'd8; fmt_8bit = 1'b0;
    flush(); clear_flag();
    for (int k = 0; k < 8; k++) push({4'hA, 4'(k), 8'h5A});
    p0 = pop_cnt;
    txstrobe = 1'b1; tick(); txstrobe = 1'b0;
    tick(); tick();
    txstrobe = 1'b1; tick(); txstrobe = 1'b0;
    check("mid strobe underrun", 32'(tx_underrun), 1);
    for (int c = 0; c < 20 && !frame_valid; c++) tick();
    check("mid strobe fv", 32'(frame_valid), 1);
    check("mid strobe pops", 32'(pop_cnt - p0), 8);
    for (int k = 0; k < 8; k++)
      check($sformatf("mid strobe ch%0d", k), 32'(ch[k]), 32'({4'hA, 4'(k), 8'h5A}));
    tick();

    // Disabled path: no reads, no underrun
    channels = 4'd0;
    flush(); clear_flag();
    for (int k = 0; k < 8; k++) push(16'h7000 + 16'(k));
    p0 = pop_cnt; r0 = rdreq_cnt; nfv = 0;
    for (int s = 0; s < 4; s++) begin
      txstrobe = 1'b1; tick(); txstrobe = 1'b0;
      if (frame_valid) nfv++;
      tick();
      if (frame_valid) nfv++;
    end
    check("ch0 rdreq count", 32'(rdreq_cnt - r0), 0);
    check("ch0 pops", 32'(pop_cnt - p0), 0);
    check("ch0 underrun", 32'(tx_underrun), 0);
    check("ch0 fv count", 32'(nfv), 0);

    // Reset mid-LOAD (outputs still hold the 0xA?5A frame)
    channels = 4'd8; fmt_8bit = 1'b0;
    flush();
    for (int k = 0; k < 8; k++) push(16'hBEE0 + 16'(k));
    txstrobe = 1'b1; tick(); txstrobe = 1'b0;
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst mid rdreq", 32'(fifo_rdreq), 0);
    check("rst mid fv", 32'(frame_valid), 0);
    check("rst mid underrun", 32'(tx_underrun), 0);
    check("rst mid debugbus", 32'(debugbus), 32'h2000);
    for (int k = 0; k < 8; k++) check($sformatf("rst mid ch%0d", k), 32'(ch[k]), 0);
    p0 = pop_cnt; nfv = 0;
    for (int c = 0; c < 12; c++) begin
      if (frame_valid) nfv++;
      tick();
    end
    check("rst mid no frame", 32'(nfv), 0);
    check("rst mid no pops", 32'(pop_cnt - p0), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
